// File: rtl/vga_pkg.sv
// Shared VGA definitions: color width, the white color used as the default
// transparency key, active-area dimensions, the RGB444 pixel type and a
// frame-start helper.
package vga_pkg;

    localparam int COLOR_W  = 12;
    localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [COLOR_W-1:0] rgb_t;

    // A frame begins on the single cycle where both counters are zero.
    function automatic logic is_frame_start(input logic [9:0] h, input logic [9:0] v);
        return (h == 10'd0) && (v == 10'd0);
    endfunction

endpackage

// File: rtl/frame_blink_timer.sv
// Frame-counted blink timer. Counts frame starts while blink is requested and
// toggles 'visible' every BLINK_FRAMES frames. Dropping 'blink' forces the
// counter to zero and the sprite visible on the very next clock, and this
// takes priority over a coincident frame start.
module frame_blink_timer
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       visible
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic             frame_start;

    assign frame_start = is_frame_start(hCount, vCount);

    // Advance the frame counter at each frame start and flip visibility on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (!blink) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                visible   <= ~visible;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prompt_sprite_overlay.sv
// Multi-prompt sprite overlay. Selects one of NUM_PROMPTS bitmaps from an
// external synchronous ROM bank, places it at (X0, Y0) with 2**SCALE_SHIFT
// upscaling and color-keys it over the background. The prompt select is
// latched only at frame start so a change never tears mid-frame.
// Two-clock latency from the raster inputs to rgb.
// Build option: define PROMPT_SPRITE_BLINK_EN to compile in the frame-counted
// blink; without it 'blink' is ignored and the sprite is always visible.
module prompt_sprite_overlay
    import vga_pkg::*;
#(
    parameter int X0           = 265,
    parameter int Y0           = 277,
    parameter int W            = 60,
    parameter int H            = 11,
    parameter int ROW_W        = 4,
    parameter int COL_W        = 6,
    parameter int NUM_PROMPTS  = 4,
    parameter int SEL_W        = 2,
    parameter int SCALE_SHIFT  = 0,
    parameter logic [COLOR_W-1:0] KEY_COLOR = WHITE,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bright,
    input  logic               en,
    input  logic               blink,
    input  logic [SEL_W-1:0]   sel,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic [COLOR_W-1:0] background,
    output logic [SEL_W-1:0]   rom_sel,
    output logic [ROW_W-1:0]   rom_row,
    output logic [COL_W-1:0]   rom_col,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [COLOR_W-1:0] rgb
);

    localparam logic [9:0]  X0_V  = 10'(X0);
    localparam logic [9:0]  Y0_V  = 10'(Y0);
    localparam logic [10:0] X_BEG = 11'(X0);
    localparam logic [10:0] X_END = 11'(X0 + (W << SCALE_SHIFT));
    localparam logic [10:0] Y_BEG = 11'(Y0);
    localparam logic [10:0] Y_END = 11'(Y0 + (H << SCALE_SHIFT));
    localparam logic [SEL_W:0] NUM_P = (SEL_W + 1)'(NUM_PROMPTS);

    logic [SEL_W-1:0]   sel_q;
    logic               frame_start;
    logic               win_h;
    logic               win_v;
    logic               sel_ok;
    logic               visible;
    logic               hit;
    logic [9:0]         h_off;
    logic [9:0]         v_off;
    logic               hit_d;
    logic               bright_d;
    rgb_t               background_d;

    assign frame_start = is_frame_start(hCount, vCount);

    // Latch the prompt select only at frame start so a frame never mixes prompts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else if (frame_start) begin
            sel_q <= sel;
        end
    end

    assign rom_sel = sel_q;

`ifdef PROMPT_SPRITE_BLINK_EN
    frame_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .blink  (blink),
        .hCount (hCount),
        .vCount (vCount),
        .visible(visible)
    );
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign visible      = 1'b1;
`endif

    // Window test and ROM addressing; offsets wrap in 10 bits and are only
    // meaningful inside the window, where hit qualifies them.
    assign win_h   = ({1'b0, hCount} >= X_BEG) && ({1'b0, hCount} < X_END);
    assign win_v   = ({1'b0, vCount} >= Y_BEG) && ({1'b0, vCount} < Y_END);
    assign h_off   = hCount - X0_V;
    assign v_off   = vCount - Y0_V;
    assign rom_col = COL_W'(h_off >> SCALE_SHIFT);
    assign rom_row = ROW_W'(v_off >> SCALE_SHIFT);
    assign sel_ok  = ({1'b0, sel_q} < NUM_P);
    assign hit     = en && win_h && win_v && sel_ok && visible;

    // Stage 1: align hit, blanking and background with the ROM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_d        <= 1'b0;
            bright_d     <= 1'b0;
            background_d <= '0;
        end else begin
            hit_d        <= hit;
            bright_d     <= bright;
            background_d <= background;
        end
    end

    // Stage 2: blank outside active video, otherwise key the sprite over the background.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else if (!bright_d) begin
            rgb <= '0;
        end else if (hit_d && (rom_color != KEY_COLOR)) begin
            rgb <= rom_color;
        end else begin
            rgb <= background_d;
        end
    end

endmodule

// File: tb/tb_prompt_sprite_overlay.sv
// Testbench for prompt_sprite_overlay. Two instances (unscaled and 2x) share
// the raster stimulus; each has its own synchronous ROM stand-in. Expected
// pixels come from a per-pixel picture model of the overlay.
module tb_prompt_sprite_overlay;

    localparam int X0           = 265;
    localparam int Y0           = 277;
    localparam int W            = 60;
    localparam int H            = 11;
    localparam int ROW_W        = 4;
    localparam int COL_W        = 6;
    localparam int NUM_PROMPTS  = 3;
    localparam int SEL_W        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam logic [11:0] KEY = 12'hFFF;

    logic             clk;
    logic             rst;
    logic             bright;
    logic             en;
    logic             blink;
    logic [SEL_W-1:0] sel;
    logic [9:0]       hCount;
    logic [9:0]       vCount;
    logic [11:0]      background;

    logic [SEL_W-1:0] rom_sel0, rom_sel1;
    logic [ROW_W-1:0] rom_row0, rom_row1;
    logic [COL_W-1:0] rom_col0, rom_col1;
    logic [11:0]      rom_color0, rom_color1;
    logic [11:0]      rgb0, rgb1;

    int checks = 0;
    int passes = 0;

    int m_selq;
    bit m_vis;
    int m_cnt;
    logic [11:0] q0[$];
    logic [11:0] q1[$];

    prompt_sprite_overlay #(
        .X0(X0), .Y0(Y0), .W(W), .H(H), .ROW_W(ROW_W), .COL_W(COL_W),
        .NUM_PROMPTS(NUM_PROMPTS), .SEL_W(SEL_W), .SCALE_SHIFT(0),
        .KEY_COLOR(KEY), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut0 (
        .clk(clk), .rst(rst), .bright(bright), .en(en), .blink(blink),
        .sel(sel), .hCount(hCount), .vCount(vCount), .background(background),
        .rom_sel(rom_sel0), .rom_row(rom_row0), .rom_col(rom_col0),
        .rom_color(rom_color0), .rgb(rgb0)
    );

    prompt_sprite_overlay #(
        .X0(X0), .Y0(Y0), .W(W), .H(H), .ROW_W(ROW_W), .COL_W(COL_W),
        .NUM_PROMPTS(NUM_PROMPTS), .SEL_W(SEL_W), .SCALE_SHIFT(1),
        .KEY_COLOR(KEY), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut1 (
        .clk(clk), .rst(rst), .bright(bright), .en(en), .blink(blink),
        .sel(sel), .hCount(hCount), .vCount(vCount), .background(background),
        .rom_sel(rom_sel1), .rom_row(rom_row1), .rom_col(rom_col1),
        .rom_color(rom_color1), .rgb(rgb1)
    );

    // Pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bitmap contents of the prompt bank; roughly one pixel in eight is transparent.
    function automatic logic [11:0] romfunc(input int s, input int r, input int c);
        logic [11:0] v;
        v = 12'(s * 12'h351 + r * 12'h0B3 + c * 12'h017 + 12'h123);
        if (v[2:0] == 3'd0) v = KEY;
        return v;
    endfunction

    // Synchronous ROM stand-ins: data one clock after the address.
    always @(posedge clk) begin
        rom_color0 <= romfunc(int'(rom_sel0), int'(rom_row0), int'(rom_col0));
        rom_color1 <= romfunc(int'(rom_sel1), int'(rom_row1), int'(rom_col1));
    end

    function automatic bit inWindow(input int scale, input int hc, input int vc);
        return (hc >= X0) && (hc < X0 + (W << scale)) && (vc >= Y0) && (vc < Y0 + (H << scale));
    endfunction

    // What the screen should show for one raster position.
    function automatic logic [11:0] expPix(input int scale, input int hc, input int vc,
                                           input bit br, input bit e, input int bg,
                                           input int selq, input bit vis);
        logic [11:0] c;
        if (!br) return 12'h000;
        if (e && vis && selq < NUM_PROMPTS && inWindow(scale, hc, vc)) begin
            c = romfunc(selq, (vc - Y0) >> scale, (hc - X0) >> scale);
            if (c != KEY) return c;
        end
        return 12'(bg);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic modelReset();
        m_selq = 0;
        m_vis  = 1'b1;
        m_cnt  = 0;
        q0 = {};
        q1 = {};
        q0.push_back(12'h000); q0.push_back(12'h000);
        q1.push_back(12'h000); q1.push_back(12'h000);
    endtask

    // One pixel clock: drive the raster inputs, check addresses and the pixel
    // due from two clocks earlier, then advance the frame-level model.
    task automatic applyStimulus(input int hc, input int vc, input bit br, input bit e,
                                 input bit bl, input int s, input int bg, input bit relRst);
        logic [11:0] ex;
        bit fs;
        @(posedge clk);
        #1;
        if (relRst) rst = 1'b0;
        hCount = 10'(hc); vCount = 10'(vc);
        bright = br; en = e; blink = bl;
        sel = SEL_W'(s); background = 12'(bg);
        @(negedge clk);
        if (relRst) modelReset();
        checkOutput("rom_sel0", 32'(rom_sel0), m_selq);
        checkOutput("rom_sel1", 32'(rom_sel1), m_selq);
        if (inWindow(0, hc, vc)) begin
            checkOutput("rom_row0", 32'(rom_row0), vc - Y0);
            checkOutput("rom_col0", 32'(rom_col0), hc - X0);
        end
        if (inWindow(1, hc, vc)) begin
            checkOutput("rom_row1", 32'(rom_row1), (vc - Y0) >> 1);
            checkOutput("rom_col1", 32'(rom_col1), (hc - X0) >> 1);
        end
        q0.push_back(expPix(0, hc, vc, br, e, bg, m_selq, m_vis));
        q1.push_back(expPix(1, hc, vc, br, e, bg, m_selq, m_vis));
        ex = q0.pop_front();
        checkOutput("rgb0", 32'(rgb0), 32'(ex));
        ex = q1.pop_front();
        checkOutput("rgb1", 32'(rgb1), 32'(ex));
        fs = (hc == 0) && (vc == 0);
        if (fs) m_selq = s;
`ifdef PROMPT_SPRITE_BLINK_EN
        if (!bl) begin
            m_cnt = 0;
            m_vis = 1'b1;
        end else if (fs) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == BLINK_FRAMES) begin
                m_cnt = 0;
                m_vis = !m_vis;
            end
        end
`endif
    endtask

    // Assert reset in the middle of a sprite pixel and confirm immediate blanking.
    task automatic resetMidPixel(input int hc, input int vc);
        @(posedge clk);
        #1;
        hCount = 10'(hc); vCount = 10'(vc);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_rgb0", 32'(rgb0), 0);
        checkOutput("rst_async_rgb1", 32'(rgb1), 0);
        checkOutput("rst_async_sel", 32'(rom_sel0), 0);
    endtask

    int bg;
    bit blinkState;

    initial begin
        rst = 1'b1;
        bright = 1'b0; en = 1'b0; blink = 1'b0; sel = '0;
        hCount = '0; vCount = '0; background = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rgb0", 32'(rgb0), 0);
        checkOutput("reset_rgb1", 32'(rgb1), 0);
        checkOutput("reset_rom_sel", 32'(rom_sel0), 0);

        // Release reset on a frame start that latches prompt 1.
        applyStimulus(0, 0, 1, 1, 0, 1, 12'h123, 1'b1);
        // Key and latency at (X0+5, Y0+3), then a run along the row.
        for (int i = 0; i < 4; i++) applyStimulus(X0 + 5, Y0 + 3, 1, 1, 0, 1, 12'h456, 1'b0);
        for (int i = 0; i < 24; i++) applyStimulus(X0 + i, Y0 + 3, 1, 1, 0, 1, 12'h0A0 + i, 1'b0);
        // Scaled window edges.
        for (int i = 116; i < 124; i++) applyStimulus(X0 + i, Y0 + 5, 1, 1, 0, 1, 12'h321, 1'b0);

        // Reset in the middle of a sprite pixel, then release.
        for (int i = 0; i < 3; i++) applyStimulus(X0 + 10 + i, Y0 + 2, 1, 1, 0, 1, 12'h777, 1'b0);
        resetMidPixel(X0 + 13, Y0 + 2);
        applyStimulus(X0 + 14, Y0 + 2, 1, 1, 0, 1, 12'h555, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(X0 + 15 + i, Y0 + 2, 1, 1, 0, 1, 12'h555, 1'b0);

        // Select latching: 1 at frame start, request 2 mid-frame, 2 next frame.
        applyStimulus(0, 0, 1, 1, 0, 1, 12'h111, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(X0 + 3 * i, 300 - 20 + i, 1, 1, 0, 2, 12'h222, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(X0 + i, 300, 1, 1, 0, 2, 12'h222, 1'b0);
        applyStimulus(0, 0, 1, 1, 0, 2, 12'h333, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(X0 + 2 * i, Y0 + i, 1, 1, 0, 2, 12'h444, 1'b0);
        // Select beyond the bank: sprite off.
        applyStimulus(0, 0, 1, 1, 0, NUM_PROMPTS, 12'h333, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(X0 + i, Y0 + 1, 1, 1, 0, 1, 12'h5A5, 1'b0);

        // Blink frames with prompt 0, then drop blink at frame 3.
        for (int f = 0; f < 6; f++) begin
            applyStimulus(0, 0, 1, 1, 1, 0, 12'h010, 1'b0);
            for (int i = 0; i < 4; i++) applyStimulus(X0 + 7 * i, Y0 + i, 1, 1, 1, 0, 12'h020 + f, 1'b0);
        end
        for (int f = 0; f < 4; f++) begin
            applyStimulus(0, 0, 1, 1, f < 3, 0, 12'h030, 1'b0);
            for (int i = 0; i < 4; i++) applyStimulus(X0 + 5 * i, Y0 + 2 * i, 1, 1, f < 3, 0, 12'h040 + f, 1'b0);
        end

        // Blanking inside the window.
        for (int i = 0; i < 10; i++) applyStimulus(X0 + i, Y0 + 4, 0, 1, 0, 0, 12'hABC, 1'b0);

        // Randomized raster around the window.
        blinkState = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            int hc, vc, s;
            if ($urandom_range(0, 199) == 0) blinkState = !blinkState;
            s  = $urandom_range(0, 3);
            bg = $urandom_range(0, 4095);
            if ($urandom_range(0, 29) == 0) begin
                hc = 0; vc = 0;
            end else if ($urandom_range(0, 19) == 0) begin
                hc = $urandom_range(0, 1023); vc = $urandom_range(0, 1023);
            end else begin
                hc = $urandom_range(X0 - 8, X0 + 2 * W + 8);
                vc = $urandom_range(Y0 - 4, Y0 + 2 * H + 4);
            end
            applyStimulus(hc, vc, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                          blinkState, s, bg, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
